// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed (DIV) support is compiled in only when SEQ_DIV_SIGNED_EN is defined.
package seq_div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W + 1);

    // Quotient reported for a zero divisor.
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in one dividend bit, then try to
// subtract the divisor. Purely combinational.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             shift_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The remainder can use all WIDTH bits when the divisor exceeds
    // 2^(WIDTH-1), so the shift and the subtract are one bit wider.
    assign shifted  = {partial_rem, shift_in};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to honour signed_i; otherwise every operation is unsigned.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs_mag;
    logic             dz;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic             q_neg;
    logic             r_neg;
    logic             accept;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign busy_o = (state == CALC) || (state == FIX);
    assign done_o = (state == DONE);
    assign accept = start_i && !busy_o;

`ifdef SEQ_DIV_SIGNED_EN
    logic dvd_sgn;
    logic dvs_sgn;

    assign dvd_sgn    = signed_i & dividend_i[WIDTH-1];
    assign dvs_sgn    = signed_i & divisor_i[WIDTH-1];
    // Negating the most-negative value gives 2^(WIDTH-1), still exact unsigned.
    assign dvd_mag_in = dvd_sgn ? -dividend_i : dividend_i;
    assign dvs_mag_in = dvs_sgn ? -divisor_i : divisor_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            q_neg <= dvd_sgn ^ dvs_sgn;
            r_neg <= dvd_sgn;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_i;
    assign dvd_mag_in    = dividend_i;
    assign dvs_mag_in    = divisor_i;
    assign q_neg         = 1'b0;
    assign r_neg         = 1'b0;
`endif

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .partial_rem (rem),
        .shift_in    (q[WIDTH-1]),
        .divisor     (dvs_mag),
        .next_rem    (step_rem),
        .q_bit       (step_bit)
    );

    assign q_fix = q_neg ? -q : q;
    assign r_fix = r_neg ? -rem : rem;

    // q doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            q           <= '0;
            dvs_mag     <= '0;
            dz          <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, matching flip-flop behaviour.
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        q       <= dvd_mag_in;
                        dvs_mag <= dvs_mag_in;
                        count   <= '0;
                        if (divisor_i == '0) begin
                            // Keep the raw dividend so it is returned with its sign.
                            dz    <= 1'b1;
                            rem   <= dividend_i;
                            state <= FIX;
                        end else begin
                            dz    <= 1'b0;
                            rem   <= '0;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    q     <= {q[WIDTH-2:0], step_bit};
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz) begin
                        quotient_o  <= {WIDTH{DIV_ZERO_Q[0]}};
                        remainder_o <= rem;
                        div_zero_o  <= 1'b1;
                    end else begin
                        quotient_o  <= q_fix;
                        remainder_o <= r_fix;
                        div_zero_o  <= 1'b0;
                    end
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
